// File: rtl/tv_pkg.sv
// Shared types and constants for the test-vector player.
package tv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Bit positions of the payload fields inside a vector word, MSB first.
    localparam int unsigned FLD_CLK  = 4;
    localparam int unsigned FLD_EN   = 3;
    localparam int unsigned FLD_RST  = 2;
    localparam int unsigned FLD_D    = 1;
    localparam int unsigned FLD_QEXP = 0;

    localparam int unsigned SET_W = 4;

    // Fields driven onto the device under test.
    typedef struct packed {
        logic clk_in;
        logic en;
        logic rst_in;
        logic d;
    } drv_t;

    // The valid flag sits just above the payload.
    function automatic int unsigned valid_bit(input int unsigned vec_w);
        return vec_w;
    endfunction

endpackage

// File: rtl/tv_player_sat_counter.sv
// Clearable counter that sticks at its all-ones value.
module sat_counter #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tv_player.sv
// Plays stimulus words from a vector memory into a flopenr-style device and
// checks its response, keeping mismatch and vector counts for status readout.
module tv_player
    import tv_pkg::*;
#(
    parameter  int unsigned VEC_W      = 5,
    parameter  int unsigned DEPTH      = 64,
    parameter  int unsigned ERR_W      = 7,
    parameter  int unsigned SETTLE_CYC = 2,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [VEC_W:0]    mem_rdata,
    output logic              dut_clk_in,
    output logic              dut_en,
    output logic              dut_rst_in,
    output logic              dut_d,
    input  logic              dut_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [ERR_W-1:0]  vec_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned VALID_BIT = valid_bit(VEC_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              qexp_q, qexp_d;
    drv_t              drv_q, drv_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;

    logic              clr_c;
    logic              err_inc_c;
    logic              vec_inc_c;
    logic [ERR_W-1:0]  err_cnt;
    logic [ERR_W-1:0]  vec_cnt;

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_c),
        .inc   (err_inc_c),
        .count (err_cnt)
    );

    sat_counter #(.W(ERR_W)) u_vec_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_c),
        .inc   (vec_inc_c),
        .count (vec_cnt)
    );

    // Sequencing: one vector is fetch, load, settle, then check.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        qexp_d      = qexp_q;
        drv_d       = drv_q;
        first_err_d = first_err_q;
        clr_c       = 1'b0;
        err_inc_c   = 1'b0;
        vec_inc_c   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    idx_d       = '0;
                    first_err_d = '0;
                    clr_c       = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!mem_rdata[VALID_BIT]) begin
                    state_d = ST_DONE;
                end else begin
                    drv_d.clk_in = mem_rdata[FLD_CLK];
                    drv_d.en     = mem_rdata[FLD_EN];
                    drv_d.rst_in = mem_rdata[FLD_RST];
                    drv_d.d      = mem_rdata[FLD_D];
                    qexp_d       = mem_rdata[FLD_QEXP];
                    settle_d     = SET_W'(SETTLE_CYC - 1);
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_CHECK: begin
                vec_inc_c = 1'b1;
                if (dut_q != qexp_q) begin
                    err_inc_c = 1'b1;
                    if (err_cnt == '0) begin
                        first_err_d = idx_q;
                    end
                end
                // The last address always ends the run; the index never wraps.
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        mem_rd_en_d = (state_d == ST_FETCH);
        mem_addr_d  = idx_d;
        busy_d      = (state_d == ST_FETCH) || (state_d == ST_LOAD) ||
                      (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d      = (state_d == ST_DONE);
        pass_d      = (state_d == ST_DONE) && (err_cnt == '0) && !err_inc_c;
        err_pulse_d = err_inc_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            settle_q    <= '0;
            qexp_q      <= 1'b0;
            drv_q       <= '0;
            first_err_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            qexp_q      <= qexp_d;
            drv_q       <= drv_d;
            first_err_q <= first_err_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign mem_rd_en      = mem_rd_en_q;
    assign mem_addr       = mem_addr_q;
    assign dut_clk_in     = drv_q.clk_in;
    assign dut_en         = drv_q.en;
    assign dut_rst_in     = drv_q.rst_in;
    assign dut_d          = drv_q.d;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_pulse      = err_pulse_q;
    assign err_count      = err_cnt;
    assign vec_count      = vec_cnt;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_tv_player.sv
// Self-checking bench for tv_player: vector memory, a toy device under test
// and a run-level reference model compared against the outputs every cycle.
module tb_tv_player;

    localparam int unsigned VEC_W  = 5;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ERR_W  = 7;
    localparam int unsigned S      = 2;
    localparam int unsigned ADDR_W = 6;
    localparam int          L      = 3 + S;
    localparam int          SATMAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [VEC_W:0]    mem_rdata = '0;
    logic              dut_clk_in, dut_en, dut_rst_in, dut_d, dut_q;
    logic              busy, done, pass, err_pulse;
    logic [ERR_W-1:0]  err_count, vec_count;
    logic [ADDR_W-1:0] first_err_addr;

    tv_player #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ERR_W(ERR_W), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dut_clk_in(dut_clk_in), .dut_en(dut_en), .dut_rst_in(dut_rst_in), .dut_d(dut_d),
        .dut_q(dut_q), .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
        .err_count(err_count), .vec_count(vec_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    logic [VEC_W:0] mem [DEPTH];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Toy device: 0 echoes d, 1 stuck low, 2 stuck high, 3 inverts d.
    int mode = 0;
    function automatic logic dut_fn(input int md, input logic d);
        case (md)
            0:       return d;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~d;
        endcase
    endfunction
    assign dut_q = dut_fn(mode, dut_d);

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a run is a list of n vectors, each taking L cycles.
    bit       m_started = 0;
    int       m_t = 0;
    int       m_n = 0;
    int       m_total = 0;
    bit       m_mism [DEPTH];
    logic [3:0] m_fld [DEPTH];
    logic [3:0] m_prev = '0;

    function automatic logic [3:0] exp_fields();
        int ld;
        if (!m_started || m_t < 2) return m_prev;
        ld = (m_t - 2) / L + 1;
        if (ld > m_n) ld = m_n;
        return (ld > 0) ? m_fld[ld-1] : m_prev;
    endfunction

    task automatic build_model();
        m_n = 0;
        while (m_n < DEPTH && mem[m_n][VEC_W] == 1'b1) m_n++;
        for (int k = 0; k < DEPTH; k++) begin
            m_fld[k]  = mem[k][4:1];
            m_mism[k] = (dut_fn(mode, mem[k][1]) != mem[k][0]);
        end
        m_total = m_n * L + ((m_n < DEPTH) ? 2 : 0);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_started = 0;
            m_t       = 0;
            m_prev    = '0;
        end else if (start && !(m_started && m_t < m_total)) begin
            m_prev    = exp_fields();
            build_model();
            m_started = 1;
            m_t       = 0;
        end else if (m_started && m_t < 100000) begin
            m_t++;
        end
    end

    // Compare process: every cycle, all outputs against the model.
    int e_err, e_vec, e_fe, c_done;
    logic e_busy, e_done, e_rd, e_pl, e_pass;
    logic [3:0] e_fld;
    always @(negedge clk) begin
        if (chk_on) begin
            e_busy = 0; e_done = 0; e_rd = 0; e_pl = 0; e_pass = 0;
            e_err = 0; e_vec = 0; e_fe = 0;
            if (m_started) begin
                e_busy = (m_t < m_total);
                e_done = !e_busy;
                e_rd   = e_busy && ((m_t < m_n * L && m_t % L == 0) ||
                                    (m_n < DEPTH && m_t == m_n * L));
                c_done = (m_t / L < m_n) ? m_t / L : m_n;
                for (int k = 0; k < c_done; k++) begin
                    if (m_mism[k]) begin
                        if (e_err == 0) e_fe = k;
                        e_err++;
                    end
                end
                e_vec = c_done;
                if (e_err > SATMAX) e_err = SATMAX;
                if (e_vec > SATMAX) e_vec = SATMAX;
                if (m_t >= L && m_t % L == 0 && m_t / L <= m_n) e_pl = m_mism[m_t/L-1];
                e_pass = e_done && (e_err == 0);
            end
            e_fld = exp_fields();
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("pass", 32'(pass), 32'(e_pass));
            check("err_pulse", 32'(err_pulse), 32'(e_pl));
            check("err_count", 32'(err_count), 32'(e_err));
            check("vec_count", 32'(vec_count), 32'(e_vec));
            check("first_err_addr", 32'(first_err_addr), 32'(e_fe));
            check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
            if (e_rd) check("mem_addr", 32'(mem_addr), 32'(m_t / L));
            check("dut_fields", 32'({dut_clk_in, dut_en, dut_rst_in, dut_d}), 32'(e_fld));
        end
    end

    // Runs one list; optional extra start pulse or reset at a given cycle offset.
    task automatic run(input int start_t, input int rst_t,
                       output int cyc, output int rd, output int rd0, output int pl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; rd = 0; rd0 = 0; pl = 0;
        while (1) begin
            rd  += int'(mem_rd_en);
            rd0 += int'(mem_rd_en && mem_addr == '0);
            pl  += int'(err_pulse);
            if (done) break;
            if (cyc >= 2000) begin
                check("done_timeout", 32'(done), 32'd1);
                break;
            end
            if (cyc == start_t) start = 1'b1;
            if (cyc == rst_t) begin
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
    endtask

    int cyc, rd, rd0, pl;
    logic [3:0] r4;

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Two passing vectors, device echoes d.
        mode = 0;
        mem[0] = 6'b1_00111; mem[1] = 6'b1_10100; mem[2] = 6'b0_00000;
        run(-1, -1, cyc, rd, rd0, pl);
        check("t1_cycles", 32'(cyc), 32'd12);
        check("t1_vec", 32'(vec_count), 32'd2);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_pass", 32'(pass), 32'd1);

        // Device stuck low: second vector mismatches.
        mode = 1;
        mem[0] = 6'b1_00110; mem[1] = 6'b1_10111;
        run(-1, -1, cyc, rd, rd0, pl);
        check("t2_pulses", 32'(pl), 32'd1);
        check("t2_err", 32'(err_count), 32'd1);
        check("t2_first_err", 32'(first_err_addr), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_fields", 32'({dut_clk_in, dut_en, dut_rst_in, dut_d}), 32'b1011);

        // Empty list.
        mem[0] = 6'b0_10101;
        run(-1, -1, cyc, rd, rd0, pl);
        check("t3_cycles", 32'(cyc), 32'd2);
        check("t3_reads", 32'(rd), 32'd1);
        check("t3_vec", 32'(vec_count), 32'd0);
        check("t3_pass", 32'(pass), 32'd1);

        // Full memory, every vector wrong.
        mode = 3;
        for (int k = 0; k < DEPTH; k++) begin
            r4 = 4'($urandom);
            mem[k] = {1'b1, r4, r4[0]};
        end
        run(-1, -1, cyc, rd, rd0, pl);
        check("t4_cycles", 32'(cyc), 32'(DEPTH * L));
        check("t4_vec", 32'(vec_count), 32'd64);
        check("t4_err", 32'(err_count), 32'd64);
        check("t4_reads", 32'(rd), 32'd64);
        check("t4_addr0_reads", 32'(rd0), 32'd1);

        // Reset in the first settle cycle of vector 3, then a clean replay.
        mode = int'($urandom_range(0, 3));
        for (int k = 0; k < 8; k++) mem[k] = {1'b1, 5'($urandom)};
        mem[8] = '0;
        run(-1, 3 * L + 2, cyc, rd, rd0, pl);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_vec", 32'(vec_count), 32'd0);
        check("t5_fields", 32'({dut_clk_in, dut_en, dut_rst_in, dut_d}), 32'd0);
        check("t5_rd_en", 32'(mem_rd_en), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        run(-1, -1, cyc, rd, rd0, pl);
        check("t5_replay_vec", 32'(vec_count), 32'd8);

        // Start during CHECK is ignored; restarting from DONE repeats the run.
        mode = 1;
        mem[0] = 6'b1_00110; mem[1] = 6'b1_10111; mem[2] = '0;
        for (int rep = 0; rep < 2; rep++) begin
            run((rep == 0) ? L - 1 : -1, -1, cyc, rd, rd0, pl);
            check("t6_cycles", 32'(cyc), 32'd12);
            check("t6_err", 32'(err_count), 32'd1);
            check("t6_vec", 32'(vec_count), 32'd2);
        end

        // Random lists and device behaviours.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? DEPTH : int'($urandom_range(0, 12));
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < DEPTH; k++) mem[k] = {1'b1, 5'($urandom)};
            if (n < DEPTH) mem[n] = {1'b0, 5'($urandom)};
            run(-1, -1, cyc, rd, rd0, pl);
            check("rand_vec", 32'(vec_count), 32'(n));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
